// File: rtl/keypad_pkg.sv
// Shared types, key constants and the row/column-to-code map for the keypad entry block.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } deb_state_e;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Bottom row carries '*' (E), '0', '#' (F) and 'D'.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM, advanced once per completed keypad scan.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done,
    input  logic       result_valid,
    input  logic [3:0] result_code,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

    deb_state_e    state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [3:0]    code_r, code_n;
    logic          fire_s;
    logic          key_valid_r;
    logic [3:0]    key_code_r;

    // State, count and captured-code registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            code_r  <= 4'h0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            code_r  <= code_n;
        end
    end

    // Next-state logic; fire_s marks the single confirming transition into HELD.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        code_n  = code_r;
        fire_s  = 1'b0;
        if (scan_done) begin
            case (state_r)
                IDLE: begin
                    if (result_valid) begin
                        code_n = result_code;
                        cnt_n  = CNT_ONE;
                        if (CNT_DONE == CNT_ONE) begin
                            state_n = HELD;
                            fire_s  = 1'b1;
                        end else begin
                            state_n = CONFIRM;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                CONFIRM: begin
                    if (result_valid && (result_code == code_r)) begin
                        cnt_n = cnt_r + CNT_ONE;
                        if (cnt_n == CNT_DONE) begin
                            state_n = HELD;
                            fire_s  = 1'b1;
                        end else begin
                            state_n = CONFIRM;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (!result_valid) begin
                        cnt_n   = CNT_ONE;
                        state_n = (CNT_DONE == CNT_ONE) ? IDLE : RELEASE;
                    end else begin
                        state_n = HELD;
                    end
                end
                RELEASE: begin
                    if (!result_valid) begin
                        cnt_n = cnt_r + CNT_ONE;
                        if (cnt_n == CNT_DONE) begin
                            state_n = IDLE;
                        end else begin
                            state_n = RELEASE;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Registered confirmation strobe and code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
        end else begin
            key_valid_r <= fire_s;
            if (fire_s) begin
                key_code_r <= result_code;
            end else begin
                key_code_r <= key_code_r;
            end
        end
    end

    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with debounce and two-digit BCD entry.
// Optional press beep is built when KEYPAD_BEEP_EN is defined.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int BEEP_CYCLES    = 2500000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       load_pulse,
    output logic       key_beep
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta_r, row_sync_r;
    logic [DW-1:0] dwell_r;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_drive_r;
    logic          dwell_last_s;

    logic [1:0]    col_cnt_s, tot_cnt_s, acc_cnt_r;
    logic [3:0]    col_code_s, tot_code_s, acc_code_r;
    logic          scan_done_r, result_valid_r;
    logic [3:0]    result_code_r;

    logic          key_valid_s;
    logic [3:0]    key_code_s;
    logic [3:0]    ones_r, tens_r;
    logic          load_pulse_r;

    assign dwell_last_s = (dwell_r == DWELL_LAST);

    // Two-flop synchroniser for the asynchronous, idle-high rows.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Dwell counter and rotating one-hot-low column drive.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            dwell_r     <= '0;
            col_idx_r   <= 2'd0;
            col_drive_r <= 4'b1110;
        end else if (dwell_last_s) begin
            dwell_r     <= '0;
            col_idx_r   <= col_idx_r + 2'd1;
            col_drive_r <= {col_drive_r[2:0], col_drive_r[3]};
        end else begin
            dwell_r     <= dwell_r + DW'(1);
            col_idx_r   <= col_idx_r;
            col_drive_r <= col_drive_r;
        end
    end

    // Keys seen in the current column, merged with the scan so far; counts saturate at 2.
    always_comb begin
        col_cnt_s  = 2'd0;
        col_code_s = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_r[r]) begin
                col_code_s = keymap(2'(r), col_idx_r);
                col_cnt_s  = (col_cnt_s == 2'd2) ? 2'd2 : col_cnt_s + 2'd1;
            end else begin
                col_cnt_s = col_cnt_s;
            end
        end
        if (col_idx_r == 2'd0) begin
            tot_cnt_s  = col_cnt_s;
            tot_code_s = col_code_s;
        end else begin
            tot_cnt_s  = ((acc_cnt_r + col_cnt_s) > 2'd2 || acc_cnt_r == 2'd2 || col_cnt_s == 2'd2)
                         ? 2'd2 : acc_cnt_r + col_cnt_s;
            tot_code_s = (col_cnt_s != 2'd0) ? col_code_s : acc_code_r;
        end
    end

    // Scan accumulator and the per-scan result handed to the debouncer.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            acc_cnt_r      <= 2'd0;
            acc_code_r     <= 4'h0;
            scan_done_r    <= 1'b0;
            result_valid_r <= 1'b0;
            result_code_r  <= 4'h0;
        end else if (dwell_last_s) begin
            acc_cnt_r      <= tot_cnt_s;
            acc_code_r     <= tot_code_s;
            scan_done_r    <= (col_idx_r == 2'd3);
            result_valid_r <= (tot_cnt_s == 2'd1);
            result_code_r  <= tot_code_s;
        end else begin
            scan_done_r    <= 1'b0;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk_50MHz),
        .reset       (reset),
        .scan_done   (scan_done_r),
        .result_valid(result_valid_r),
        .result_code (result_code_r),
        .key_valid   (key_valid_s),
        .key_code    (key_code_s)
    );

    // Digit entry: shift in 0-9, clear on '*', strobe load on '#'.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            ones_r       <= 4'h0;
            tens_r       <= 4'h0;
            load_pulse_r <= 1'b0;
        end else begin
            load_pulse_r <= 1'b0;
            if (key_valid_s) begin
                case (key_code_s)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                        tens_r <= ones_r;
                        ones_r <= key_code_s;
                    end
                    KEY_CLEAR: begin
                        tens_r <= 4'h0;
                        ones_r <= 4'h0;
                    end
                    KEY_ENTER: load_pulse_r <= 1'b1;
                    default:   load_pulse_r <= 1'b0;
                endcase
            end else begin
                ones_r <= ones_r;
            end
        end
    end

`ifdef KEYPAD_BEEP_EN
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    logic [BW-1:0] beep_cnt_r;
    logic          beep_r;

    // Beep stays high BEEP_CYCLES cycles after each confirmed key; a new key restarts it.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            beep_cnt_r <= '0;
            beep_r     <= 1'b0;
        end else if (key_valid_s) begin
            beep_cnt_r <= BW'(BEEP_CYCLES - 1);
            beep_r     <= 1'b1;
        end else if (beep_cnt_r != '0) begin
            beep_cnt_r <= beep_cnt_r - BW'(1);
            beep_r     <= 1'b1;
        end else begin
            beep_r     <= 1'b0;
        end
    end

    assign key_beep = beep_r;
`else
    assign key_beep = 1'b0;
`endif

    assign col_drive  = col_drive_r;
    assign key_valid  = key_valid_s;
    assign key_code   = key_code_s;
    assign ones       = ones_r;
    assign tens       = tens_r;
    assign load_pulse = load_pulse_r;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with SCAN_DIV=8, DEBOUNCE_SCANS=2 (one scan = 32 cycles).
module tb_keypad_bcd_entry;

    localparam int SCAN = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] ones, tens;
    logic       load_pulse, key_beep;

    logic [15:0] keys = 16'h0000;   // bit index = row*4 + col

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;
    int kv_cnt   = 0;
    int lp_cnt   = 0;
    int lp_wide  = 0;
    logic lp_prev = 1'b0;
    logic [3:0] kv_codes[$];

    keypad_bcd_entry #(
        .SCAN_DIV      (8),
        .DEBOUNCE_SCANS(2),
        .BEEP_CYCLES   (20)
    ) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_valid (key_valid),
        .key_code  (key_code),
        .ones      (ones),
        .tens      (tens),
        .load_pulse(load_pulse),
        .key_beep  (key_beep)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row is pulled low when a pressed key sits in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_drive);
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            kv_codes.push_back(key_code);
        end
        if (load_pulse) lp_cnt++;
        if (load_pulse && lp_prev) lp_wide++;
        lp_prev <= load_pulse;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] mask, input int scans);
        keys = mask;
        hold(scans * SCAN);
    endtask

    // Wait (bounded) for col_drive to return to column 0, i.e. a new scan.
    task automatic align_scan();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev = col_drive;
        for (int i = 0; i < 2 * SCAN && !found; i++) begin
            @(negedge clk);
            if (col_drive == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = col_drive;
        end
        check("scan_align", {31'd0, found}, 32'd1);
    endtask

    int base, lp_base;

    initial begin
        hold(3);
        check("rst_col",  {28'd0, col_drive}, 32'hE);
        check("rst_ones", {28'd0, ones}, 32'h0);
        check("rst_tens", {28'd0, tens}, 32'h0);
        check("rst_kv",   {31'd0, key_valid}, 32'h0);
        check("rst_lp",   {31'd0, load_pulse}, 32'h0);
        reset = 1'b0;
        hold(8); check("col_step1", {28'd0, col_drive}, 32'hD);
        hold(8); check("col_step2", {28'd0, col_drive}, 32'hB);
        hold(8); check("col_step3", {28'd0, col_drive}, 32'h7);
        hold(8); check("col_step4", {28'd0, col_drive}, 32'hE);

        // Digit entry: '4' then '7'.
        base = kv_cnt;
        press(16'h0010, 5); press(16'h0000, 5);
        press(16'h0100, 5); press(16'h0000, 5);
        check("entry_kv_count", kv_cnt - base, 32'd2);
        check("entry_code0", {28'd0, kv_codes[base]}, 32'h4);
        check("entry_code1", {28'd0, kv_codes[base + 1]}, 32'h7);
        check("entry_tens", {28'd0, tens}, 32'h4);
        check("entry_ones", {28'd0, ones}, 32'h7);

        // Bounce on '2': present, absent, present, then absent.
        align_scan();
        base = kv_cnt;
        press(16'h0002, 1); press(16'h0000, 1); press(16'h0002, 1);
        keys = 16'h0000; hold(SCAN + 10);
        check("bounce_no_kv", kv_cnt - base, 32'd0);
        press(16'h0002, 2); press(16'h0000, 5);
        check("bounce_kv_count", kv_cnt - base, 32'd1);
        check("bounce_code", {28'd0, kv_codes[base]}, 32'h2);

        // Two keys at once never confirm; long hold confirms once.
        base = kv_cnt;
        press(16'h0021, 5); press(16'h0000, 4);
        check("multi_no_kv", kv_cnt - base, 32'd0);
        press(16'h0400, 10); press(16'h0000, 4);
        check("hold_kv_count", kv_cnt - base, 32'd1);
        check("hold_code", {28'd0, kv_codes[base]}, 32'h9);

        // Enter 3,8 then '#' and '*'.
        press(16'h0004, 4); press(16'h0000, 4);
        press(16'h0200, 4); press(16'h0000, 4);
        check("preset_tens", {28'd0, tens}, 32'h3);
        check("preset_ones", {28'd0, ones}, 32'h8);
        lp_base = lp_cnt;
        press(16'h4000, 4); press(16'h0000, 4);
        check("enter_lp_count", lp_cnt - lp_base, 32'd1);
        check("enter_lp_width", lp_wide, 32'd0);
        check("enter_tens", {28'd0, tens}, 32'h3);
        check("enter_ones", {28'd0, ones}, 32'h8);
        lp_base = lp_cnt;
        press(16'h1000, 4); press(16'h0000, 4);
        check("clear_tens", {28'd0, tens}, 32'h0);
        check("clear_ones", {28'd0, ones}, 32'h0);
        check("clear_no_lp", lp_cnt - lp_base, 32'd0);

        // Reset while '6' is in CONFIRM and still held.
        press(16'h0020, 4); press(16'h0000, 4);
        check("pre_rst_ones", {28'd0, ones}, 32'h5);
        align_scan();
        keys = 16'h0040;
        hold(SCAN + 6);
        reset = 1'b1;
        hold(3);
        check("mid_rst_col",  {28'd0, col_drive}, 32'hE);
        check("mid_rst_ones", {28'd0, ones}, 32'h0);
        check("mid_rst_tens", {28'd0, tens}, 32'h0);
        check("mid_rst_kv",   {31'd0, key_valid}, 32'h0);
        check("mid_rst_lp",   {31'd0, load_pulse}, 32'h0);
        base = kv_cnt;
        reset = 1'b0;
        hold(40);
        check("post_rst_no_early_kv", kv_cnt - base, 32'd0);
        hold(40);
        check("post_rst_kv_count", kv_cnt - base, 32'd1);
        check("post_rst_code", {28'd0, kv_codes[base]}, 32'h6);
        press(16'h0000, 4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/keypad_bcd_entry.md
# keypad_bcd_entry

Scans a 4x4 matrix keypad, debounces key presses, and assembles a two-digit BCD value (tens, ones) with a one-cycle load strobe. It is the input-side counterpart of the multiplexed 7-segment driver: it scans keypad columns where the display scans digits. It sits beside the 1 Hz generator in the stopwatch top level and feeds the preset value and load strobe to the digit counter.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (1 ms at 50 MHz); legal range ≥ 8.
- DEBOUNCE_SCANS, 4: consecutive full scans needed to confirm a press or a release; legal range ≥ 1.
- BEEP_CYCLES, 2500000: key_beep pulse length in cycles (50 ms); only used with the Configuration macro.

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- row_in  in  4  keypad rows, active-low, pulled up externally; asynchronous to the clock.
- col_drive  out  4  column drive, active-low, one-hot-low; reset value 4'b1110.
- key_valid  out  1  one-cycle pulse when a press is confirmed; reset value 0.
- key_code  out  4  code of the confirmed key; meaningful only while key_valid is high; reset value 0.
- ones  out  4  BCD ones digit entered; reset value 0.
- tens  out  4  BCD tens digit entered; reset value 0.
- load_pulse  out  1  one-cycle strobe meaning "enter pressed"; reset value 0.
- key_beep  out  1  press-feedback pulse; reset value 0.

## Operation
- Scanning:
  - A column index 0..3 rotates continuously.
  - A dwell counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 the synchronised rows are sampled and the column advances, wrapping 3 to 0.
  - row_in passes through a 2-flop synchroniser before it is sampled.
- Key map (row,col to code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Scan result, evaluated after column 3 is sampled:
  - Exactly one key down across the scan: result is that code.
  - Zero keys, or two or more keys: result is "none".
- Debounce FSM, advancing once per completed scan:
  - IDLE: a code result goes to CONFIRM, capturing the code and setting count=1.
  - CONFIRM: the same code increments count. When count reaches DEBOUNCE_SCANS: go to HELD, assert key_valid for one cycle, drive key_code. A different code or "none" returns to IDLE.
  - HELD: a "none" result goes to RELEASE with count=1. A code result stays in HELD; there is no repeat.
  - RELEASE: "none" increments count, and DEBOUNCE_SCANS reached returns to IDLE. A code result returns to HELD.
  - With DEBOUNCE_SCANS=1, IDLE goes straight to HELD on the first scan with a code, asserting key_valid.
- Entry logic on key_valid:
  - Codes 0–9: tens←ones, ones←code (shift left). The old tens value is discarded.
  - E: ones←0, tens←0.
  - F: load_pulse=1 for one cycle; ones and tens are unchanged.
  - A–D: ignored.
- Reset mid-scan or mid-debounce: everything returns to the reset values listed under Interface, and the FSM goes to IDLE. A key still held through reset must be re-confirmed by the full debounce sequence.

## Timing
- A stable single key is confirmed DEBOUNCE_SCANS full scans after the first scan in which it appears. Worst case is (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles.
- key_valid, key_code, and the FSM transition are registered on the cycle after the column-3 sample edge.
- ones, tens and load_pulse update on the edge where key_valid is high, so they are visible 1 cycle after key_valid.
- load_pulse is never wider than 1 cycle. At most one key_valid occurs per press/release cycle.
- col_drive changes on the same edge the dwell counter wraps. Rows are sampled from the synchroniser at SCAN_DIV-1, which allows ≥ 6 cycles of settling.

## Configuration
- KEYPAD_BEEP_EN defined:
  - key_beep goes high on the cycle after key_valid, for BEEP_CYCLES cycles, for every confirmed key including A–D.
  - A new key_valid during a beep restarts the count.
- KEYPAD_BEEP_EN undefined: key_beep is tied 0 and the beep counter is not built.

## Structure
- Package keypad_pkg holds:
  - the debounce state enum (IDLE, CONFIRM, HELD, RELEASE);
  - constants KEY_CLEAR=4'hE and KEY_ENTER=4'hF;
  - a keymap function taking (row, col) and returning the 4-bit code.
- One sub-module, keypad_debounce, contains the FSM and count and takes {scan_done, result_valid, result_code}. The scanner, synchroniser, entry registers and beep counter stay in keypad_bcd_entry.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_SCANS=2.
- Reset: after reset, col_drive=4'b1110, ones=tens=0, key_valid=load_pulse=0, and col_drive steps 1110→1101→1011→0111→1110 every 8 cycles.
- Digit entry: press key "4" (row1,col0), release, then press "7" (row2,col0) and release → one key_valid per press with key_code 4 then 7; finally tens=4, ones=7.
- Bounce: key "2" present for 1 scan, absent 1 scan, present 1 scan → no key_valid. Then held for 2 scans → exactly one key_valid with key_code=2.
- Multi-key and hold: "1" and "5" held together for 5 scans → no key_valid. Key "9" held for 10 scans → exactly one key_valid.
- Clear and enter: with tens=3 and ones=8, press "#" → load_pulse for 1 cycle, digits unchanged. Then press "*" → ones=tens=0, no load_pulse.
- Reset mid-confirm: assert reset while in CONFIRM for "6", with the key still held → all outputs return to reset values. After release of reset, key_valid fires only after 2 more full scans.
